// File: rtl/bus_grant_encoder.sv
// bus_grant_encoder: registered request-to-index encoder with arbitration,
// lock-hold and stall. Fixed priority (lowest index wins) by default; define
// BUS_GRANT_RR_EN to build a round-robin pointer instead.
//
// state | meaning
// IDLE  | no grant active, valid=0
// GRANT | grant active on grant_idx, valid=1
module bus_grant_encoder #(
  parameter int N = 32,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clock,
  input  logic         clear_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         lock,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic         valid,
  output logic         multi
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] idx_nxt;
  logic [N-1:0] oh_nxt;
  logic         multi_nxt;
  logic [W-1:0] win_idx;
  logic         win_found;
  logic         hold;

`ifdef BUS_GRANT_RR_EN
  logic [W-1:0] ptr, ptr_nxt;
`endif

  assign valid = (state == GRANT);
  assign hold  = (state == GRANT) && lock && req[grant_idx];

  // Winner search: first set request starting from the priority origin.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
`ifdef BUS_GRANT_RR_EN
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
`else
      j = i;
`endif
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        win_idx   = W'(j);
      end
    end
  end

  // Next-state and next-output logic; stall keeps everything as is.
  always_comb begin
    state_nxt = state;
    idx_nxt   = grant_idx;
    oh_nxt    = grant_onehot;
    multi_nxt = multi;
`ifdef BUS_GRANT_RR_EN
    ptr_nxt   = ptr;
`endif
    if (en) begin
      if (hold) begin
        multi_nxt = 1'b0;
      end else if (win_found) begin
        state_nxt = GRANT;
        idx_nxt   = win_idx;
        oh_nxt    = N'(1) << win_idx;
        multi_nxt = ($countones(req) > 1);
`ifdef BUS_GRANT_RR_EN
        ptr_nxt   = (win_idx == W'(N - 1)) ? '0 : win_idx + 1'b1;
`endif
      end else begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        oh_nxt    = '0;
        multi_nxt = 1'b0;
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state        <= IDLE;
      grant_idx    <= '0;
      grant_onehot <= '0;
      multi        <= 1'b0;
    end else begin
      state        <= state_nxt;
      grant_idx    <= idx_nxt;
      grant_onehot <= oh_nxt;
      multi        <= multi_nxt;
    end
  end

`ifdef BUS_GRANT_RR_EN
  // Round-robin origin register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) ptr <= '0;
    else          ptr <= ptr_nxt;
  end
`endif

endmodule

// File: tb/tb_bus_grant_encoder.sv
// Bench for bus_grant_encoder: N=32 and N=12 instances checked every cycle
// against a vector-level model, plus hand-computed literal expectations.
module tb_bus_grant_encoder;

  logic        clock = 1'b0;
  logic        clear_n, en, lock;
  logic [31:0] req32;
  logic [11:0] req12;
  logic [4:0]  gi32;
  logic [31:0] oh32;
  logic        v32, m32o;
  logic [3:0]  gi12;
  logic [11:0] oh12;
  logic        v12, m12o;

  int total = 0;
  int bad   = 0;

  bus_grant_encoder #(.N(32)) dut32 (
    .clock(clock), .clear_n(clear_n), .en(en), .req(req32), .lock(lock),
    .grant_idx(gi32), .grant_onehot(oh32), .valid(v32), .multi(m32o));

  bus_grant_encoder #(.N(12)) dut12 (
    .clock(clock), .clear_n(clear_n), .en(en), .req(req12), .lock(lock),
    .grant_idx(gi12), .grant_onehot(oh12), .valid(v12), .multi(m12o));

  initial forever #5 clock = ~clock;

  typedef struct {
    bit valid;
    int idx;
    bit multi;
    int ptr;
  } mdl_t;

  mdl_t m32, m12;

  function automatic int log2_pow(logic [63:0] v);
    int k = 0;
    while (v > 64'd1) begin
      v = v >> 1;
      k++;
    end
    return k;
  endfunction

  // Rotate the request vector so the priority origin sits at bit 0, isolate
  // the lowest set bit, then rotate the answer back.
  function automatic mdl_t mdl_next(mdl_t s, logic [63:0] r, bit e, bit lk, int n);
    mdl_t t;
    logic [63:0] mask, rot, iso;
    int p, cnt, w;
    t = s;
    if (!e) return t;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    r = r & mask;
    if (s.valid && lk && r[s.idx]) begin
      t.multi = 1'b0;
      return t;
    end
    cnt = $countones(r);
    if (cnt == 0) begin
      t.valid = 1'b0;
      t.idx   = 0;
      t.multi = 1'b0;
      return t;
    end
`ifdef BUS_GRANT_RR_EN
    p = s.ptr;
`else
    p = 0;
`endif
    rot = ((r >> p) | (r << (n - p))) & mask;
    iso = rot & (~rot + 64'd1);
    w = (log2_pow(iso) + p) % n;
    t.valid = 1'b1;
    t.idx   = w;
    t.multi = (cnt > 1);
    t.ptr   = (w + 1) % n;
    return t;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model advance on the same edges as the design.
  always @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      m32 = '{1'b0, 0, 1'b0, 0};
      m12 = '{1'b0, 0, 1'b0, 0};
    end else begin
      m32 = mdl_next(m32, 64'(req32), en, lock, 32);
      m12 = mdl_next(m12, 64'(req12), en, lock, 12);
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clock) begin
    if (clear_n) begin
      chk("idx32",   64'(gi32), 64'(m32.idx));
      chk("oh32",    64'(oh32), m32.valid ? (64'd1 << m32.idx) : 64'd0);
      chk("valid32", 64'(v32),  64'(m32.valid));
      chk("multi32", 64'(m32o), 64'(m32.multi));
      chk("idx12",   64'(gi12), 64'(m12.idx));
      chk("oh12",    64'(oh12), m12.valid ? (64'd1 << m12.idx) : 64'd0);
      chk("valid12", 64'(v12),  64'(m12.valid));
      chk("multi12", 64'(m12o), 64'(m12.multi));
      chk("idx12_range", 64'(gi12 < 4'd12), 64'd1);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    clear_n = 1'b0;
    #2;
    clear_n = 1'b1;
  endtask

  int rr_exp[4];

  initial begin
`ifdef BUS_GRANT_RR_EN
    rr_exp = '{1, 4, 31, 1};
`else
    rr_exp = '{1, 1, 1, 1};
`endif
    clear_n = 1'b0; en = 1'b1; lock = 1'b0; req32 = '0; req12 = '0;
    #12;
    chk("rst_idx",   64'(gi32), 64'd0);
    chk("rst_oh",    64'(oh32), 64'd0);
    chk("rst_valid", 64'(v32),  64'd0);
    chk("rst_multi", 64'(m32o), 64'd0);
    chk("rst_v12",   64'(v12),  64'd0);
    @(posedge clock); #1;
    clear_n = 1'b1;

    // single request
    req32 = 32'h0000_0400;
    step();
    chk("single_idx",   64'(gi32), 64'd10);
    chk("single_oh",    64'(oh32), 64'h400);
    chk("single_valid", 64'(v32),  64'd1);
    chk("single_multi", 64'(m32o), 64'd0);

    // contention
    pulse_reset();
    req32 = 32'h8000_0012;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("cont_idx",   64'(gi32), 64'(rr_exp[k]));
      chk("cont_multi", 64'(m32o), 64'd1);
    end

    // lock and release
    pulse_reset();
    req32 = 32'h0000_0010; lock = 1'b1;
    step();
    chk("lock_idx", 64'(gi32), 64'd4);
    req32 = 32'h0000_0011;
    step();
    chk("lock_hold_idx",   64'(gi32), 64'd4);
    chk("lock_hold_multi", 64'(m32o), 64'd0);
    req32 = 32'h0000_0001;
    step();
    chk("lock_rel_idx", 64'(gi32), 64'd0);
    req32 = 32'h0;
    step();
    chk("drop_valid", 64'(v32),  64'd0);
    chk("drop_idx",   64'(gi32), 64'd0);
    lock = 1'b0;

    // stall and mid-operation reset
    req32 = 32'h8000_0000;
    step();
    chk("stall_pre_idx", 64'(gi32), 64'd31);
    en = 1'b0; req32 = 32'h0000_0003; lock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_idx",   64'(gi32), 64'd31);
      chk("stall_valid", 64'(v32),  64'd1);
      chk("stall_oh",    64'(oh32), 64'h8000_0000);
    end
    #2 clear_n = 1'b0;
    #1;
    chk("async_valid", 64'(v32),  64'd0);
    chk("async_oh",    64'(oh32), 64'd0);
    clear_n = 1'b1; en = 1'b1; lock = 1'b0; req32 = '0;

    // non-power-of-two width
    pulse_reset();
    req12 = 12'h800;
    step();
    chk("n12_idx", 64'(gi12), 64'd11);
    chk("n12_oh",  64'(oh12), 64'h800);
    req12 = 12'h801;
    step();
    chk("n12_wrap_idx",   64'(gi12), 64'd0);
    chk("n12_wrap_multi", 64'(m12o), 64'd1);
    req12 = 12'hFFF;
    repeat (14) step();

    // mixed traffic against the model
    for (int k = 0; k < 80; k++) begin
      req32 = $urandom() & $urandom();
      req12 = 12'($urandom() & $urandom());
      lock  = ($urandom_range(0, 2) != 0);
      en    = ($urandom_range(0, 4) != 0);
      step();
    end

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
